// File: rtl/instr_stim_gen.sv
// Constrained-random RV32I instruction source driven by a 32-bit Galois LFSR.
// Issues a NOP warm-up, then a bounded run of OP-IMM/LOAD/STORE/OP words over valid/ready.
module instr_stim_gen #(
    parameter logic [31:0] SEED          = 32'h0000_0001,
    parameter int unsigned WARMUP_NOPS   = 2,
    parameter int unsigned NUM_INSTR     = 64,
    parameter logic [4:0]  REG_MASK      = 5'h1F,
    parameter logic [2:0]  LOAD_F3_MASK  = 3'b100,
    parameter logic [2:0]  STORE_F3_MASK = 3'b001,
    parameter logic [11:0] IMM_L_MASK    = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [3:0]  mode_en,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_count,
    output logic        done
);

    typedef enum logic [1:0] {ST_RST, ST_WARM, ST_GEN, ST_DONE} state_e;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [31:0] SEED_NZ   = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam int          WARM_W    = (WARMUP_NOPS < 2) ? 1 : $clog2(WARMUP_NOPS + 1);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP_NOPS);
    localparam logic [15:0] RUN_LEN   = 16'(NUM_INSTR);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [31:0] encode(input logic [29:0] a, input logic [17:0] b,
                                           input logic [3:0] men);
        logic [11:0] imm, imm_x, off;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3, f3l, f3s;
        logic [1:0]  sel, idx, mode;
        logic        found, f7b;
        logic [31:0] word;
        imm  = a[11:0];
        rs1  = a[16:12] & REG_MASK;
        rs2  = a[21:17] & REG_MASK;
        rd   = a[26:22] & REG_MASK;
        f3   = a[29:27];
        sel  = b[1:0];
        f3l  = b[4:2] & LOAD_F3_MASK;
        f3s  = b[4:2] & STORE_F3_MASK;
        off  = b[16:5] & IMM_L_MASK;
        f7b  = b[17];
        // First enabled mode at or after sel, wrapping modulo 4.
        found = 1'b0;
        mode  = sel;
        for (int k = 0; k < 4; k++) begin
            idx = sel + 2'(k);
            if (!found && men[idx]) begin
                mode  = idx;
                found = 1'b1;
            end
        end
        case (f3)
            3'd1:    imm_x = imm & 12'h01F;
            3'd5:    imm_x = imm & 12'h41F;
            default: imm_x = imm;
        endcase
        word = NOP;
        if (found) begin
            case (mode)
                2'd0: word = {imm_x, rs1, f3, rd, 7'b0010011};
                2'd1: word = {off, rs1, f3l, rd, 7'b0000011};
                2'd2: word = {off[11:5], rs2, rs1, f3s, off[4:0], 7'b0100011};
                default: word = {1'b0, f7b & ((f3 == 3'd0) | (f3 == 3'd5)), 5'b0,
                                 rs2, rs1, f3, rd, 7'b0110011};
            endcase
        end
        return word;
    endfunction

    state_e            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [31:0]       instr_q, instr_d;
    logic [15:0]       count_q, count_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [31:0]       draw_a, draw_b, rand_word;
    logic              fire, last_fire;
    logic              unused_draw_bits;

    assign draw_a    = lfsr_step(lfsr_q);
    assign draw_b    = lfsr_step(draw_a);
    assign rand_word = encode(draw_a[29:0], draw_b[17:0], mode_en);
    assign unused_draw_bits = ^{draw_a[31:30], draw_b[31:18]};

    assign instr_valid = en & (((state_q == ST_WARM) & (warm_q != '0)) | (state_q == ST_GEN));
    assign fire        = instr_valid & instr_ready;
    assign last_fire   = (RUN_LEN != 16'd0) && (count_q + 16'd1 == RUN_LEN);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        instr_d = instr_q;
        count_d = count_q;
        warm_d  = warm_q;
        if (seed_load) begin
            lfsr_d  = (seed_in == 32'd0) ? 32'd1 : seed_in;
            count_d = 16'd0;
            instr_d = NOP;
            warm_d  = WARM_INIT;
            state_d = ST_WARM;
        end else if (en) begin
            case (state_q)
                ST_RST: begin
                    warm_d  = WARM_INIT;
                    state_d = ST_WARM;
                end
                ST_WARM: begin
                    // An empty warm-up falls through without presenting any NOP.
                    if ((warm_q == '0) || (fire && (warm_q == WARM_W'(1)))) begin
                        warm_d  = '0;
                        instr_d = rand_word;
                        lfsr_d  = draw_b;
                        state_d = ST_GEN;
                    end else if (fire) begin
                        warm_d = warm_q - WARM_W'(1);
                    end
                end
                ST_GEN: begin
                    if (fire) begin
                        count_d = sat_inc(count_q);
                        if (last_fire) begin
                            instr_d = NOP;
                            state_d = ST_DONE;
                        end else begin
                            instr_d = rand_word;
                            lfsr_d  = draw_b;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RST;
            lfsr_q  <= SEED_NZ;
            instr_q <= NOP;
            count_q <= 16'd0;
            warm_q  <= WARM_INIT;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            instr_q <= instr_d;
            count_q <= count_d;
            warm_q  <= warm_d;
        end
    end

    assign instr       = instr_q;
    assign instr_count = count_q;
    assign done        = (state_q == ST_DONE);

endmodule
